// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and constants for the hazard/forwarding controller: forward-select
// codes, control-bundle bit positions and the pipeline shadow-slot record.
package hazard_forward_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int M_READ   = 2;
  localparam int M_WRITE  = 1;
  localparam int M_BRANCH = 0;

  localparam int WB_MEMTOREG = 1;
  localparam int WB_REGWRITE = 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/hfc_fwd_sel.sv
// Forward-source selector for one EX operand; a younger MEM-stage producer
// shadows an older WB-stage producer of the same register.
module hfc_fwd_sel
  import hazard_forward_ctrl_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic [4:0] ex_rs_i,
  input  logic       mem_valid_i,
  input  logic       mem_regwrite_i,
  input  logic [4:0] mem_rd_i,
  input  logic       wb_valid_i,
  input  logic       wb_regwrite_i,
  input  logic [4:0] wb_rd_i,
  output logic [1:0] fwd_o
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = mem_valid_i && mem_regwrite_i && (mem_rd_i != 5'd0) && (mem_rd_i == ex_rs_i);
    wb_hit  = wb_valid_i && wb_regwrite_i && (wb_rd_i != 5'd0) && (wb_rd_i == ex_rs_i);
    fwd_o   = FWD_RF;
    if (ex_valid_i) begin
      if (mem_hit)     fwd_o = FWD_EXMEM;
      else if (wb_hit) fwd_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Load-use stall, branch flush and operand-forwarding control for a 5-stage
// pipeline, tracked through EX/MEM/WB shadow slots plus saturating event counters.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  input  logic [2:0]  id_M_i,
  input  logic [1:0]  id_WB_i,
  input  logic        mem_branch_taken_i,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic        stall_o,
  output logic        bubble_o,
  output logic        flush_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  slot_t       ex_q, ex_d;
  slot_t       mem_q, mem_d;
  slot_t       wb_q, wb_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        load_use;

  // Bits that carry no hazard information are folded here so they stay intentionally unused.
  logic unused_ok;
  assign unused_ok = ^{id_M_i[M_WRITE], id_M_i[M_BRANCH], id_WB_i[WB_MEMTOREG],
                       wb_q.rs1, wb_q.rs2, wb_q.memread};

  always_comb begin
    load_use = id_valid_i && ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) &&
               ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));
    flush_o  = mem_branch_taken_i;
    stall_o  = load_use && !mem_branch_taken_i;
    bubble_o = stall_o;

    ex_d.valid    = id_valid_i;
    ex_d.rs1      = id_rs1_i;
    ex_d.rs2      = id_rs2_i;
    ex_d.rd       = id_rd_i;
    ex_d.regwrite = id_WB_i[WB_REGWRITE];
    ex_d.memread  = id_M_i[M_READ];
    mem_d         = ex_q;
    wb_d          = mem_q;
    if (flush_o) begin
      ex_d  = SLOT_BUBBLE;
      mem_d = SLOT_BUBBLE;
    end else if (stall_o) begin
      ex_d  = SLOT_BUBBLE;
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_o && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush_o && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_q        <= SLOT_BUBBLE;
      mem_q       <= SLOT_BUBBLE;
      wb_q        <= SLOT_BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  hfc_fwd_sel u_fwd_a (
    .ex_valid_i     (ex_q.valid),
    .ex_rs_i        (ex_q.rs1),
    .mem_valid_i    (mem_q.valid),
    .mem_regwrite_i (mem_q.regwrite),
    .mem_rd_i       (mem_q.rd),
    .wb_valid_i     (wb_q.valid),
    .wb_regwrite_i  (wb_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .fwd_o          (fwd_a_o)
  );

  hfc_fwd_sel u_fwd_b (
    .ex_valid_i     (ex_q.valid),
    .ex_rs_i        (ex_q.rs2),
    .mem_valid_i    (mem_q.valid),
    .mem_regwrite_i (mem_q.regwrite),
    .mem_rd_i       (mem_q.rd),
    .wb_valid_i     (wb_q.valid),
    .wb_regwrite_i  (wb_q.regwrite),
    .wb_rd_i        (wb_q.rd),
    .fwd_o          (fwd_b_o)
  );

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed-vector bench for hazard_forward_ctrl: forwarding priority, load-use
// stall, flush priority, reset override and counter saturation.
module tb_hazard_forward_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [2:0]  id_M_i;
  logic [1:0]  id_WB_i;
  logic        mem_branch_taken_i;
  logic [1:0]  fwd_a_o, fwd_b_o;
  logic        stall_o, bubble_o, flush_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  hazard_forward_ctrl dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .id_valid_i         (id_valid_i),
    .id_rs1_i           (id_rs1_i),
    .id_rs2_i           (id_rs2_i),
    .id_rd_i            (id_rd_i),
    .id_M_i             (id_M_i),
    .id_WB_i            (id_WB_i),
    .mem_branch_taken_i (mem_branch_taken_i),
    .fwd_a_o            (fwd_a_o),
    .fwd_b_o            (fwd_b_o),
    .stall_o            (stall_o),
    .bubble_o           (bubble_o),
    .flush_o            (flush_o),
    .stall_cnt_o        (stall_cnt_o),
    .flush_cnt_o        (flush_cnt_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive the ID-stage instruction and let combinational outputs settle.
  task automatic applyStimulus(input logic valid, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [2:0] m, input logic [1:0] wb,
                               input logic br);
    id_valid_i         = valid;
    id_rs1_i           = rs1;
    id_rs2_i           = rs2;
    id_rd_i            = rd;
    id_M_i             = m;
    id_WB_i            = wb;
    mem_branch_taken_i = br;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 2'b00, 1'b0);
    stepClock();
    stepClock();
    rst_i = 1'b1;
    #1;
    checkOutput("rst_fwd_a", {30'd0, fwd_a_o}, 32'd0);
    checkOutput("rst_fwd_b", {30'd0, fwd_b_o}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall_o}, 32'd0);
    checkOutput("rst_bubble", {31'd0, bubble_o}, 32'd0);
    checkOutput("rst_flush", {31'd0, flush_o}, 32'd0);
    checkOutput("rst_stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
    checkOutput("rst_flush_cnt", {16'd0, flush_cnt_o}, 32'd0);

    // add x5 reaches MEM while the consumer (rs1=5, rs2=7) is in EX
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 3'b000, 2'b01, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd5, 5'd7, 5'd8, 3'b000, 2'b01, 1'b0);
    checkOutput("alu_dep_no_stall", {31'd0, stall_o}, 32'd0);
    stepClock();
    checkOutput("mem_fwd_a", {30'd0, fwd_a_o}, 32'h2);
    checkOutput("mem_fwd_b_none", {30'd0, fwd_b_o}, 32'h0);

    // MEM and WB both write x5: the younger MEM result must win
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 3'b000, 2'b01, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd3, 5'd4, 5'd5, 3'b000, 2'b01, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd0, 5'd5, 5'd9, 3'b000, 2'b01, 1'b0);
    stepClock();
    checkOutput("prio_fwd_b", {30'd0, fwd_b_o}, 32'h2);
    checkOutput("prio_fwd_a_x0", {30'd0, fwd_a_o}, 32'h0);

    // Same shape with rd=x0 never forwards
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd0, 3'b000, 2'b01, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd3, 5'd4, 5'd0, 3'b000, 2'b01, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd9, 3'b000, 2'b01, 1'b0);
    stepClock();
    checkOutput("x0_fwd_b", {30'd0, fwd_b_o}, 32'h0);
    checkOutput("x0_fwd_a", {30'd0, fwd_a_o}, 32'h0);

    // MEM matches but does not write, WB writes x6: WB path selected
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd6, 3'b000, 2'b01, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd6, 3'b000, 2'b00, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd6, 5'd1, 5'd9, 3'b000, 2'b01, 1'b0);
    stepClock();
    checkOutput("wb_fwd_a", {30'd0, fwd_a_o}, 32'h1);
    checkOutput("wb_fwd_b_none", {30'd0, fwd_b_o}, 32'h0);

    // Store/branch bits and memtoreg without read/regwrite: no stall, no forward
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd20, 3'b011, 2'b10, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd20, 5'd20, 5'd21, 3'b000, 2'b01, 1'b0);
    checkOutput("ignored_bits_stall", {31'd0, stall_o}, 32'd0);
    stepClock();
    checkOutput("ignored_bits_fwd_a", {30'd0, fwd_a_o}, 32'h0);

    // Load-use: ld x9 then add rs1=9
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd9, 3'b100, 2'b11, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd9, 5'd3, 5'd10, 3'b000, 2'b01, 1'b0);
    checkOutput("lu_stall", {31'd0, stall_o}, 32'd1);
    checkOutput("lu_bubble", {31'd0, bubble_o}, 32'd1);
    stepClock();
    checkOutput("lu_stall_released", {31'd0, stall_o}, 32'd0);
    checkOutput("lu_bubble_fwd_a", {30'd0, fwd_a_o}, 32'h0);
    stepClock();
    checkOutput("lu_fwd_a", {30'd0, fwd_a_o}, 32'h1);
    checkOutput("lu_fwd_b", {30'd0, fwd_b_o}, 32'h0);
    checkOutput("lu_stall_cnt", {16'd0, stall_cnt_o}, 32'd1);

    // Load-use coinciding with a taken branch: flush wins
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd12, 3'b100, 2'b11, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd12, 5'd0, 5'd14, 3'b000, 2'b01, 1'b1);
    checkOutput("flush_flush", {31'd0, flush_o}, 32'd1);
    checkOutput("flush_stall", {31'd0, stall_o}, 32'd0);
    checkOutput("flush_bubble", {31'd0, bubble_o}, 32'd0);
    stepClock();
    checkOutput("flush_cnt", {16'd0, flush_cnt_o}, 32'd1);
    checkOutput("flush_stall_cnt", {16'd0, stall_cnt_o}, 32'd1);
    applyStimulus(1'b1, 5'd14, 5'd12, 5'd15, 3'b000, 2'b01, 1'b0);
    checkOutput("flush_ex_invalid_no_stall", {31'd0, stall_o}, 32'd0);
    stepClock();
    checkOutput("flush_ex_squashed", {30'd0, fwd_a_o}, 32'h0);
    checkOutput("flush_mem_squashed", {30'd0, fwd_b_o}, 32'h0);

    // Reset during a stall cycle
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd9, 3'b100, 2'b11, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd9, 5'd9, 5'd10, 3'b000, 2'b01, 1'b0);
    checkOutput("pre_rst_stall", {31'd0, stall_o}, 32'd1);
    rst_i = 1'b0;
    stepClock();
    rst_i = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 2'b00, 1'b0);
    checkOutput("rst2_stall", {31'd0, stall_o}, 32'd0);
    checkOutput("rst2_bubble", {31'd0, bubble_o}, 32'd0);
    checkOutput("rst2_flush", {31'd0, flush_o}, 32'd0);
    checkOutput("rst2_fwd", {28'd0, fwd_a_o, fwd_b_o}, 32'h0);
    checkOutput("rst2_stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
    checkOutput("rst2_flush_cnt", {16'd0, flush_cnt_o}, 32'd0);

    // Hold branch taken 65540 cycles; flush counter must saturate
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 2'b00, 1'b1);
    repeat (65534) stepClock();
    checkOutput("sat_pre", {16'd0, flush_cnt_o}, 32'h0000FFFE);
    repeat (6) stepClock();
    checkOutput("sat_flush_cnt", {16'd0, flush_cnt_o}, 32'h0000FFFF);
    checkOutput("sat_stall_cnt", {16'd0, stall_cnt_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 SHALL have no parameters; all widths are fixed (5-bit register ids, 3-bit M bundle, 2-bit WB bundle, 16-bit counters).
REQ-002 clk_i  in  1  sole clock; all state updates on posedge.
REQ-003 rst_i  in  1  synchronous, active-low reset.
REQ-004 id_valid_i  in  1  ID stage holds a real instruction.
REQ-005 id_rs1_i, id_rs2_i  in  5 each  source register ids of the ID instruction (instr[19:15], instr[24:20]).
REQ-006 id_rd_i  in  5  destination id of the ID instruction (instr[11:7]).
REQ-007 id_M_i  in  3  {memread, memwrite, branch} of the ID instruction, same encoding the ID/EX register emits.
REQ-008 id_WB_i  in  2  {memtoreg, regwrite} of the ID instruction.
REQ-009 mem_branch_taken_i  in  1  beq in MEM resolved taken this cycle.
REQ-010 fwd_a_o, fwd_b_o  out  2 each  ALU operand source for the EX instruction: 00 regfile/ID-EX, 10 EX/MEM, 01 MEM/WB.
REQ-011 stall_o  out  1  hold PC and IF/ID this cycle.
REQ-012 bubble_o  out  1  load zero control into ID/EX at next edge.
REQ-013 flush_o  out  1  squash IF/ID, ID/EX and EX/MEM at next edge.
REQ-014 stall_cnt_o, flush_cnt_o  out  16 each  saturating event counters.

Function
REQ-015 SHALL keep three shadow slots, EX, MEM and WB; each holds {valid, rs1, rs2, rd, regwrite, memread}, and all slots advance on every clock edge.
REQ-016 Normal advance: EX <= ID inputs (valid = id_valid_i), MEM <= EX, WB <= MEM.
REQ-017 stall_o SHALL equal id_valid_i & EX.valid & EX.memread & EX.rd!=0 & (EX.rd==id_rs1_i | EX.rd==id_rs2_i) & !mem_branch_taken_i, driven combinationally.
REQ-018 On stall, EX SHALL load a bubble (valid=0, regwrite=0, memread=0); MEM and WB advance normally; bubble_o = stall_o.
REQ-019 A load-use stall SHALL last exactly 1 cycle; the dependent instruction then forwards via 01.
REQ-020 flush_o = mem_branch_taken_i; on flush, EX and MEM SHALL load bubbles and WB advances from MEM.
REQ-021 Flush takes priority over stall: stall_o=0 and bubble_o=0 in a flush cycle.
REQ-022 fwd_a_o SHALL be 10 if MEM.valid & MEM.regwrite & MEM.rd!=0 & MEM.rd==EX.rs1; else 01 if the same test holds on WB; else 00.
REQ-023 fwd_b_o SHALL be computed as in REQ-022 using EX.rs2.
REQ-024 The MEM-stage match wins when MEM and WB both match; rd==x0 never forwards and never stalls.
REQ-025 fwd_a_o and fwd_b_o SHALL be 00 when EX.valid=0.
REQ-026 stall_cnt_o SHALL increment once per cycle with stall_o=1; flush_cnt_o SHALL increment once per cycle with flush_o=1.
REQ-027 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-028 The memwrite and branch bits of id_M_i and the memtoreg bit of id_WB_i SHALL not affect any output.

Reset
REQ-029 rst_i=0 at an edge SHALL clear all slot fields, stall_cnt_o and flush_cnt_o to 0.
REQ-030 Reset SHALL override stall, flush and counting in the same edge.
REQ-031 In the cycle after reset, with id_valid_i=0: fwd_a_o=fwd_b_o=00 and stall_o=bubble_o=0; flush_o follows mem_branch_taken_i.

Structure
REQ-032 The shared package SHALL hold the forward-select codes (FWD_RF=00, FWD_EXMEM=10, FWD_MEMWB=01), the bit indices of the M bundle (READ=2, WRITE=1, BRANCH=0) and of the WB bundle (MEMTOREG=1, REGWRITE=0), and the slot record type.
REQ-033 SHALL contain one sub-module, hfc_fwd_sel, a comparator/priority selector instantiated twice (operands A and B).

Verification
REQ-034 add x5 in MEM (regwrite=1), EX rs1=5, rs2=7 -> fwd_a_o=10, fwd_b_o=00.
REQ-035 MEM.rd=WB.rd=5, both regwrite, EX rs2=5 -> fwd_b_o=10; repeat with rd=0 -> 00.
REQ-036 ld x9 in EX, ID add rs1=9 -> stall_o=bubble_o=1 for exactly 1 cycle; next cycle fwd_a_o=01; stall_cnt_o=1.
REQ-037 Load-use condition plus mem_branch_taken_i=1 in the same cycle -> flush_o=1, stall_o=0; next cycle EX/MEM slots invalid; flush_cnt_o=1.
REQ-038 rst_i=0 during a stall cycle -> next cycle all outputs 0 and counters 0.
REQ-039 mem_branch_taken_i held 1 for 65540 cycles -> flush_cnt_o stops at 16'hFFFF.
